// File: rtl/hazard_unit_sb.sv
// Pipeline hazard unit: forwarding selects, load-use bubbles, long-latency
// scoreboard with an in-flight limit, and a pending flush that survives cache stalls.
module hazard_unit_sb #(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int MAX_LL       = 2,
  localparam int NUM_REGS    = 2**REG_ADDR_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_dec,
  input  logic                  i_ll_instr_dec,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
  input  logic                  i_reg_we_mem,
  input  logic                  i_reg_we_wb,
  input  logic                  i_load_instr_exec,
  input  logic                  i_ll_issue_exec,
  input  logic                  i_ll_done,
  input  logic [REG_ADDR_W-1:0] i_ll_rd_done,
  input  logic                  i_pc_src_exec,
  input  logic                  i_stall_i,
  input  logic                  i_stall_d,
  output logic                  o_stall_fetch,
  output logic                  o_stall_dec,
  output logic                  o_stall_exec,
  output logic                  o_stall_mem,
  output logic                  o_flush_dec,
  output logic                  o_flush_exec,
  output logic [1:0]            o_forward_rs1,
  output logic [1:0]            o_forward_rs2,
  output logic [2:0]            o_ll_count,
  output logic [NUM_REGS-1:0]   o_sb_pending
);

  localparam logic [2:0] BUBBLE_LOAD = 3'(LOAD_BUBBLES - 1);
  localparam logic [2:0] LL_LIMIT    = 3'(MAX_LL);

  logic [NUM_REGS-1:0] sbPend_q, sbPend_d;
  logic [2:0]          bcnt_q, bcnt_d;
  logic [2:0]          llCount_q, llCount_d;
  logic                flushPend_q, flushPend_d;

  logic extStall;
  logic flushNow;
  logic luHit;
  logic luStall;
  logic sbHit;
  logic capStall;
  logic decHold;
  logic llIssue;
  logic llInc;
  logic llDec;
  logic memFwd1, memFwd2, wbFwd1, wbFwd2;

  // Mem beats wb, and x0 never forwards since it is never really written.
  assign memFwd1 = i_reg_we_mem && (i_rd_addr_mem != '0) && (i_rs1_addr_exec == i_rd_addr_mem);
  assign memFwd2 = i_reg_we_mem && (i_rd_addr_mem != '0) && (i_rs2_addr_exec == i_rd_addr_mem);
  assign wbFwd1  = i_reg_we_wb  && (i_rd_addr_wb  != '0) && (i_rs1_addr_exec == i_rd_addr_wb);
  assign wbFwd2  = i_reg_we_wb  && (i_rd_addr_wb  != '0) && (i_rs2_addr_exec == i_rd_addr_wb);

  assign o_forward_rs1 = memFwd1 ? 2'b10 : (wbFwd1 ? 2'b01 : 2'b00);
  assign o_forward_rs2 = memFwd2 ? 2'b10 : (wbFwd2 ? 2'b01 : 2'b00);

  // A redirect seen while the caches are stalled is replayed once they release.
  assign extStall = i_stall_i | i_stall_d;
  assign flushNow = (i_pc_src_exec | flushPend_q) & ~extStall;

  assign luHit = (i_load_instr_exec | i_ll_issue_exec) && (i_rd_addr_exec != '0) &&
                 ((i_rs1_addr_dec == i_rd_addr_exec) || (i_rs2_addr_dec == i_rd_addr_exec));
  assign luStall = (luHit || (bcnt_q != 3'd0)) && !flushNow;

  assign sbHit = sbPend_q[i_rs1_addr_dec] | sbPend_q[i_rs2_addr_dec] | sbPend_q[i_rd_addr_dec];

  // A completion in the same cycle frees a slot, so the new op need not wait.
  assign capStall = i_ll_instr_dec && (llCount_q == LL_LIMIT) && !i_ll_done;

  assign decHold = luStall | ((sbHit | capStall) & ~flushNow);

  assign o_stall_fetch = decHold | extStall;
  assign o_stall_dec   = decHold | extStall;
  assign o_stall_exec  = i_stall_d;
  assign o_stall_mem   = i_stall_d;
  assign o_flush_dec   = flushNow;
  assign o_flush_exec  = flushNow | (decHold & ~extStall);
  assign o_ll_count    = llCount_q;
  assign o_sb_pending  = sbPend_q;

  assign llIssue = i_ll_issue_exec & ~i_stall_d;
  assign llDec   = i_ll_done & (llCount_q != 3'd0);
  assign llInc   = llIssue & ((llCount_q != LL_LIMIT) | llDec);

  // Next-state for the pending flush and the load-use bubble counter.
  always_comb begin
    flushPend_d = flushPend_q;
    if (flushNow) begin
      flushPend_d = 1'b0;
    end else if (i_pc_src_exec && extStall) begin
      flushPend_d = 1'b1;
    end

    bcnt_d = bcnt_q;
    if (flushNow) begin
      bcnt_d = 3'd0;
    end else if (luHit && !i_stall_d) begin
      bcnt_d = BUBBLE_LOAD;
    end else if ((bcnt_q != 3'd0) && !i_stall_d) begin
      bcnt_d = bcnt_q - 3'd1;
    end
  end

  // Scoreboard and in-flight count; a set on the same bit as a clear wins.
  always_comb begin
    sbPend_d = sbPend_q;
    if (i_ll_done) begin
      sbPend_d[i_ll_rd_done] = 1'b0;
    end
    if (llIssue && (i_rd_addr_exec != '0)) begin
      sbPend_d[i_rd_addr_exec] = 1'b1;
    end
    sbPend_d[0] = 1'b0;

    llCount_d = llCount_q;
    if (llInc && !llDec) begin
      llCount_d = llCount_q + 3'd1;
    end else if (llDec && !llInc) begin
      llCount_d = llCount_q - 3'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sbPend_q    <= '0;
      bcnt_q      <= 3'd0;
      llCount_q   <= 3'd0;
      flushPend_q <= 1'b0;
    end else begin
      sbPend_q    <= sbPend_d;
      bcnt_q      <= bcnt_d;
      llCount_q   <= llCount_d;
      flushPend_q <= flushPend_d;
    end
  end

endmodule
